uart_tx_fifo_reader: RTL



---
 rtl/uart_tx_fifo_reader.sv | 132 +++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo_reader.sv
// UART transmitter that drains the TX byte FIFO onto the serial line.
// Frame: start, DATA_SIZE bits LSB first, optional parity, stop period.
module uart_tx_fifo_reader #(
    parameter int DATA_SIZE  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int SB_TICK    = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_tick,
    input  logic                 tx_en,
    input  logic                 fifo_empty,
    input  logic [DATA_SIZE-1:0] fifo_rdata,
    output logic                 fifo_rd,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done_tick
);
    localparam int MAX_TICK = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
    localparam int TW = (MAX_TICK > 1) ? $clog2(MAX_TICK) : 1;
    localparam int BW = $clog2(DATA_SIZE + 1);

    localparam logic [TW-1:0] OS_LAST  = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] SB_LAST  = TW'(SB_TICK - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_SIZE - 1);
    localparam logic          PAR_ODD  = (PARITY_ODD != 0);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]           state;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_SIZE-1:0] shift_reg;
    logic [DATA_SIZE-1:0] data_word;
    logic                 tx_reg;
    logic                 os_last;
    logic                 stop_last;
    logic                 pop;

    assign os_last   = (tick_cnt == OS_LAST);
    assign stop_last = (state == STOP) && (tick_cnt == SB_LAST);

    // A pop on the last stop tick chains frames with no idle gap.
    assign pop = s_tick && tx_en && !fifo_empty && !reset
              && ((state == IDLE) || stop_last);

    assign fifo_rd      = pop;
    assign tx_done_tick = s_tick && stop_last && !reset;
    assign tx_busy      = (state != IDLE);
    assign tx           = tx_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            data_word <= '0;
            tx_reg    <= 1'b1;
        end else if (pop) begin
            state     <= START;
            tick_cnt  <= '0;
            shift_reg <= fifo_rdata;
            data_word <= fifo_rdata;
            tx_reg    <= 1'b0;
        end else if (s_tick) begin
            unique case (state)
                IDLE: begin
                    tx_reg <= 1'b1;
                end
                START: begin
                    if (os_last) begin
                        state    <= DATA;
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                        tx_reg   <= shift_reg[0];
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (os_last) begin
                        tick_cnt  <= '0;
                        shift_reg <= shift_reg >> 1;
                        bit_cnt   <= bit_cnt + 1'b1;
                        if (bit_cnt == BIT_LAST) begin
                            if (PARITY_EN != 0) begin
                                state  <= PARITY;
                                tx_reg <= (^data_word) ^ PAR_ODD;
                            end else begin
                                state  <= STOP;
                                tx_reg <= 1'b1;
                            end
                        end else begin
                            tx_reg <= shift_reg[1];
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (os_last) begin
                        state    <= STOP;
                        tick_cnt <= '0;
                        tx_reg   <= 1'b1;
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (stop_last) begin
                        state    <= IDLE;
                        tick_cnt <= '0;
                        tx_reg   <= 1'b1;
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    tx_reg <= 1'b1;
                end
            endcase
        end
    end
endmodule
